// File: rtl/subleq_pkg.sv
// Shared state encoding, instruction geometry and address helper for the SUBLEQ core.
package subleq_pkg;

  typedef enum logic [2:0] {
    S_IA,
    S_RA,
    S_IB,
    S_RB,
    S_IC,
    S_WB,
    S_HALT
  } state_t;

  localparam int INSTR_WORDS = 3;
  localparam int MAX_W       = 64;

  // Keeps only the low addr_w bits of a data word; callers cast the result down to ADDR_W.
  function automatic logic [MAX_W-1:0] addr_of(input logic [MAX_W-1:0] word, input int addr_w);
    logic [MAX_W-1:0] mask;
    mask = (addr_w >= MAX_W) ? '1 : ((MAX_W'(1) << addr_w) - MAX_W'(1));
    return word & mask;
  endfunction

endpackage

// File: rtl/subleq_alu.sv
// Wrapping DATA_W subtract b - a with a signed "result <= 0" flag.
module subleq_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              leq
);

  always_comb begin
    result = b - a;
    leq    = result[DATA_W-1] | (result == '0);
  end

endmodule

// File: rtl/subleq_core_p.sv
// Multi-cycle SUBLEQ core with a req/ack memory port, run gating and self-loop halt.
// Define SUBLEQ_IO_EN to map writes to the all-ones address onto the o_io_valid/o_io_data port.
module subleq_core_p
  import subleq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_run,
  output logic              o_req,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_retired,
  output logic              o_halted
`ifdef SUBLEQ_IO_EN
  ,
  output logic              o_io_valid,
  output logic [DATA_W-1:0] o_io_data
`endif
);

  state_t            state, state_next, state_after;
  logic [ADDR_W-1:0] pc, a_ptr, b_ptr, c_tgt;
  logic [DATA_W-1:0] a_val, b_val, result;
  logic              leq, done, io_hit, self_loop;

  subleq_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_val),
    .b      (b_val),
    .result (result),
    .leq    (leq)
  );

`ifdef SUBLEQ_IO_EN
  assign io_hit     = i_rstn && (state == S_WB) && (b_ptr == '1);
  assign o_io_valid = io_hit;
  assign o_io_data  = io_hit ? result : '0;
`else
  assign io_hit = 1'b0;
`endif

  assign self_loop = leq && (c_tgt == pc);
  assign o_pc      = pc;

  // Outputs decode straight from registered state so they hold steady until the ack arrives.
  always_comb begin
    o_req       = 1'b0;
    o_we        = 1'b0;
    o_addr      = '0;
    o_wdata     = '0;
    state_after = state;
    case (state)
      S_IA: begin
        if (i_run) begin
          o_req  = 1'b1;
          o_addr = pc;
        end
        state_after = S_RA;
      end
      S_RA: begin
        o_req       = 1'b1;
        o_addr      = a_ptr;
        state_after = S_IB;
      end
      S_IB: begin
        o_req       = 1'b1;
        o_addr      = pc + ADDR_W'(1);
        state_after = S_RB;
      end
      S_RB: begin
        o_req       = 1'b1;
        o_addr      = b_ptr;
        state_after = S_IC;
      end
      S_IC: begin
        o_req       = 1'b1;
        o_addr      = pc + ADDR_W'(2);
        state_after = S_WB;
      end
      S_WB: begin
        if (!io_hit) begin
          o_req   = 1'b1;
          o_we    = 1'b1;
          o_addr  = b_ptr;
          o_wdata = result;
        end
        state_after = self_loop ? S_HALT : S_IA;
      end
      default: state_after = S_HALT;
    endcase
    if (!i_rstn) begin
      o_req   = 1'b0;
      o_we    = 1'b0;
      o_addr  = '0;
      o_wdata = '0;
    end
    done       = (o_req && i_ack) || io_hit;
    state_next = done ? state_after : state;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= S_IA;
      pc        <= ADDR_W'(RESET_PC);
      a_ptr     <= '0;
      b_ptr     <= '0;
      c_tgt     <= '0;
      a_val     <= '0;
      b_val     <= '0;
      o_retired <= 1'b0;
      o_halted  <= 1'b0;
    end else begin
      state     <= state_next;
      o_retired <= 1'b0;
      if (done) begin
        case (state)
          S_IA: a_ptr <= ADDR_W'(addr_of(MAX_W'(i_rdata), ADDR_W));
          S_RA: a_val <= i_rdata;
          S_IB: b_ptr <= ADDR_W'(addr_of(MAX_W'(i_rdata), ADDR_W));
          S_RB: b_val <= i_rdata;
          S_IC: c_tgt <= ADDR_W'(addr_of(MAX_W'(i_rdata), ADDR_W));
          S_WB: begin
            pc        <= leq ? c_tgt : pc + ADDR_W'(INSTR_WORDS);
            o_retired <= 1'b1;
            o_halted  <= self_loop;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
